hangman_host: RTL and testbench
===============================

Name: hangman_host

Overview:
- Receive-side game engine. Consumes the ASCII letter bytes that the keypad front end produces and ships over UART, and runs the hangman rules.
- Loads a secret word, checks each guess against it sequentially, and tracks revealed positions, mistakes and win/lose.
- Emits one response byte per processed input through a valid/ready transmit handshake.
- Sits between the UART receive port and the UART transmit port / display logic.

Parameters:
- WORD_LEN, 5, number of letters in the secret word (2..8).
- MAX_MISTAKES, 6, misses allowed before loss (1..7).

Ports:
- clk  input  1  system clock (10 MHz)
- nRst  input  1  asynchronous active-low reset
- rx_data  input  8  received byte
- rx_ready  input  1  one-cycle pulse: rx_data valid this cycle
- tx_data  output  8  response byte
- tx_valid  output  1  response byte pending
- tx_ready  input  1  transmitter accepts byte this cycle
- mask  output  WORD_LEN  bit i=1: position i revealed
- mistakes  output  3  miss count
- game_over  output  1  win or loss reached
- win  output  1  word fully revealed
- overrun  output  1  sticky: byte arrived while busy
- state  output  3  current FSM state, for debug display

Behaviour:
- Reset (async, nRst=0):
  - State = LOAD. word index = 0. word storage and guessed-letter bitmap (26 bits) cleared.
  - mask=0, mistakes=0, game_over=0, win=0, overrun=0, tx_valid=0, tx_data=8'h00.
- Byte classes:
  - Letter: 8'h41..8'h5A.
  - Restart: 8'h21 '!'.
  - 8'h00 and 8'h5F '_' (keypad idle/clear codes): ignored silently, no response.
  - All other bytes: ignored silently.
- Restart: accepted in LOAD, WAIT and END only. Same effect as reset except overrun is also cleared. No response byte.
- States (encoding): LOAD=0, WAIT=1, CHECK=2, UPDATE=3, REPORT=4, END=5.
- LOAD:
  - Each rx_ready with a letter writes word[idx], then idx++.
  - When idx reaches WORD_LEN: response 'K' (8'h4B), go to REPORT, then WAIT.
- WAIT: rx_ready with a letter latches guess and goes to CHECK next cycle.
- CHECK:
  - One position per cycle, i = 0..WORD_LEN-1, exactly WORD_LEN cycles.
  - Position i matches if word[i]==guess; a hit vector accumulates.
- UPDATE (1 cycle):
  - Guess letter already set in bitmap -> response '=' (8'h3D). mask and mistakes unchanged.
  - Else set bitmap bit (guess-8'h41).
  - hit vector nonzero -> mask |= hits, response '+' (8'h2B).
  - hit vector zero -> mistakes++, response '-' (8'h2D).
  - If mask becomes all ones -> win=1, game_over=1, response 'W' (8'h57); overrides '+'.
  - If mistakes reaches MAX_MISTAKES -> game_over=1, response 'L' (8'h4C); overrides '-'.
- REPORT:
  - tx_valid=1 with tx_data stable until tx_ready is sampled high.
  - tx_valid drops the next cycle.
  - Next state: END if game_over, else WAIT.
  - tx_ready high on the first REPORT cycle means a 1-cycle transfer.
- END:
  - Letters ignored; only Restart is honoured.
  - mask, mistakes, win and game_over hold their values.
- Latency: guess rx_ready at cycle t -> tx_valid rises at t+WORD_LEN+2.
- Busy overrun: rx_ready with any non-ignored byte during CHECK, UPDATE or REPORT:
  - Byte dropped, overrun=1 (sticky).
  - Restart bytes arriving in these states are also dropped and set overrun.
- Reset mid-operation: immediately returns to the reset state. Any pending tx byte is discarded and tx_valid falls asynchronously.
- mistakes saturates at MAX_MISTAKES. mask bits beyond WORD_LEN do not exist.

Optional Feature:
- Macro: HANGMAN_CASE_FOLD_EN.
- Defined: lowercase 8'h61..8'h7A is folded to uppercase (minus 8'h20) before classification, in LOAD and in WAIT.
- Undefined: lowercase bytes are ignored silently, like any other non-letter.

Test Plan:
- Load "HELLO" (48 45 4C 4C 4F) -> tx 'K' (8'h4B) once; state goes to WAIT; mask=00000.
- Guess 'L' -> tx '+' at t+7 (WORD_LEN=5); mask=bits 2,3 set; mistakes=0.
- Guess 'L' again -> tx '='; mask and mistakes unchanged.
- Guess 'Z','Q','X','V','J','B' -> five '-' responses then 'L'; mistakes=6; game_over=1; win=0; further letters produce no tx.
- Guess H,E,L,O with tx_ready held low 10 cycles on the last response -> tx_valid and tx_data=8'h57 held stable until accept; win=1; then Restart '!' -> state LOAD, mask=0, mistakes=0.
- Send a letter 2 cycles after a guess (during CHECK) -> byte dropped, overrun=1; assert nRst=0 mid-CHECK -> all outputs at reset values immediately.

Source files
------------

// File: rtl/hangman_host.sv
// Hangman game engine on the UART receive side: loads a secret word, scores guesses, reports one byte per result.
// Optional HANGMAN_CASE_FOLD_EN: fold lowercase ASCII to uppercase in LOAD and WAIT.
module hangman_host #(
  parameter int unsigned WORD_LEN     = 5,
  parameter int unsigned MAX_MISTAKES = 6
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic [7:0]          rx_data,
  input  logic                rx_ready,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [WORD_LEN-1:0] mask,
  output logic [2:0]          mistakes,
  output logic                game_over,
  output logic                win,
  output logic                overrun,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_WAIT   = 3'd1,
    S_CHECK  = 3'd2,
    S_UPDATE = 3'd3,
    S_REPORT = 3'd4,
    S_END    = 3'd5
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'(WORD_LEN - 1);
  localparam logic [2:0] MAX_M    = 3'(MAX_MISTAKES);

  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_DUP  = 8'h3D;
  localparam logic [7:0] RSP_HIT  = 8'h2B;
  localparam logic [7:0] RSP_MISS = 8'h2D;
  localparam logic [7:0] RSP_WIN  = 8'h57;
  localparam logic [7:0] RSP_LOSE = 8'h4C;

  state_e                    state_q, state_d;
  logic [3:0]                idx_q, idx_d;
  logic [WORD_LEN-1:0][7:0]  word_q, word_d;
  logic [25:0]               bitmap_q, bitmap_d;
  logic [7:0]                guess_q, guess_d;
  logic [WORD_LEN-1:0]       hits_q, hits_d;
  logic [WORD_LEN-1:0]       mask_q, mask_d;
  logic [2:0]                mistakes_q, mistakes_d;
  logic                      game_over_q, game_over_d;
  logic                      win_q, win_d;
  logic                      overrun_q, overrun_d;
  logic [7:0]                tx_data_q, tx_data_d;
  logic                      tx_valid_q, tx_valid_d;

  logic [7:0]          in_byte;
  logic                is_letter;
  logic                is_restart;
  logic                raw_live;
  logic [25:0]         guess_oh;
  logic                already;
  logic [WORD_LEN-1:0] new_mask;
  logic [2:0]          new_mistakes;
  logic                clear;

  always_comb begin
    in_byte = rx_data;
`ifdef HANGMAN_CASE_FOLD_EN
    if (rx_data >= 8'h61 && rx_data <= 8'h7A) begin
      in_byte = rx_data - 8'h20;
    end
`endif
  end

  assign is_letter  = (in_byte >= 8'h41) && (in_byte <= 8'h5A);
  assign is_restart = (in_byte == 8'h21);
  // Busy states see the raw byte: folding only applies where bytes are consumed.
  assign raw_live   = ((rx_data >= 8'h41) && (rx_data <= 8'h5A)) || (rx_data == 8'h21);

  always_comb begin
    guess_oh = '0;
    for (int unsigned i = 0; i < 26; i++) begin
      guess_oh[i] = (guess_q == (8'h41 + 8'(i)));
    end
  end

  assign already      = |(bitmap_q & guess_oh);
  assign new_mask     = mask_q | hits_q;
  assign new_mistakes = (mistakes_q < MAX_M) ? (mistakes_q + 3'd1) : mistakes_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    bitmap_d    = bitmap_q;
    guess_d     = guess_q;
    hits_d      = hits_q;
    mask_d      = mask_q;
    mistakes_d  = mistakes_q;
    game_over_d = game_over_q;
    win_d       = win_q;
    overrun_d   = overrun_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    clear       = 1'b0;

    unique case (state_q)
      S_LOAD: begin
        if (rx_ready) begin
          if (is_restart) begin
            clear = 1'b1;
          end else if (is_letter) begin
            for (int unsigned i = 0; i < WORD_LEN; i++) begin
              if (idx_q == 4'(i)) word_d[i] = in_byte;
            end
            if (idx_q == LAST_IDX) begin
              idx_d      = '0;
              tx_data_d  = RSP_OK;
              tx_valid_d = 1'b1;
              state_d    = S_REPORT;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
      end

      S_WAIT: begin
        if (rx_ready) begin
          if (is_restart) begin
            clear = 1'b1;
          end else if (is_letter) begin
            guess_d = in_byte;
            hits_d  = '0;
            idx_d   = '0;
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (rx_ready && raw_live) overrun_d = 1'b1;
        for (int unsigned i = 0; i < WORD_LEN; i++) begin
          if (idx_q == 4'(i)) hits_d[i] = (word_q[i] == guess_q);
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_UPDATE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      S_UPDATE: begin
        if (rx_ready && raw_live) overrun_d = 1'b1;
        tx_valid_d = 1'b1;
        state_d    = S_REPORT;
        if (already) begin
          tx_data_d = RSP_DUP;
        end else begin
          bitmap_d = bitmap_q | guess_oh;
          if (|hits_q) begin
            mask_d = new_mask;
            if (&new_mask) begin
              win_d       = 1'b1;
              game_over_d = 1'b1;
              tx_data_d   = RSP_WIN;
            end else begin
              tx_data_d = RSP_HIT;
            end
          end else begin
            mistakes_d = new_mistakes;
            if (new_mistakes == MAX_M) begin
              game_over_d = 1'b1;
              tx_data_d   = RSP_LOSE;
            end else begin
              tx_data_d = RSP_MISS;
            end
          end
        end
      end

      S_REPORT: begin
        if (rx_ready && raw_live) overrun_d = 1'b1;
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = game_over_q ? S_END : S_WAIT;
        end
      end

      S_END: begin
        if (rx_ready && is_restart) clear = 1'b1;
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase

    if (clear) begin
      state_d     = S_LOAD;
      idx_d       = '0;
      word_d      = '0;
      bitmap_d    = '0;
      guess_d     = '0;
      hits_d      = '0;
      mask_d      = '0;
      mistakes_d  = '0;
      game_over_d = 1'b0;
      win_d       = 1'b0;
      overrun_d   = 1'b0;
      tx_data_d   = '0;
      tx_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      word_q      <= '0;
      bitmap_q    <= '0;
      guess_q     <= '0;
      hits_q      <= '0;
      mask_q      <= '0;
      mistakes_q  <= '0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
      overrun_q   <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      bitmap_q    <= bitmap_d;
      guess_q     <= guess_d;
      hits_q      <= hits_d;
      mask_q      <= mask_d;
      mistakes_q  <= mistakes_d;
      game_over_q <= game_over_d;
      win_q       <= win_d;
      overrun_q   <= overrun_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign mask      = mask_q;
  assign mistakes  = mistakes_q;
  assign game_over = game_over_q;
  assign win       = win_q;
  assign overrun   = overrun_q;
  assign state     = state_q;

endmodule

// File: tb/tb_hangman_host.sv
// Directed bench for hangman_host: table of guesses with expected responses plus load, overrun and reset sequences.
`timescale 1ns/1ps
module tb_hangman_host;

  localparam int unsigned WL = 5;

  logic          clk = 1'b0;
  logic          nRst;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [WL-1:0] mask;
  logic [2:0]    mistakes;
  logic          game_over;
  logic          win;
  logic          overrun;
  logic [2:0]    state;

  hangman_host #(.WORD_LEN(WL), .MAX_MISTAKES(6)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mask      (mask),
    .mistakes  (mistakes),
    .game_over (game_over),
    .win       (win),
    .overrun   (overrun),
    .state     (state)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic [7:0]  rx;
    int unsigned hold;
    logic [7:0]  tx;
    logic [4:0]  mask;
    logic [2:0]  mist;
    logic        go;
    logic        win;
  } vec_t;

  vec_t vecs[12];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Loads HELLO with ignored bytes (lowercase, '_', NUL) interleaved.
  task automatic load_hello();
    send_byte(8'h48);
    send_byte(8'h68);
    send_byte(8'h45);
    send_byte(8'h5F);
    send_byte(8'h4C);
    send_byte(8'h00);
    send_byte(8'h4C);
    check("load_no_tx_early", {31'd0, tx_valid}, 32'd0);
    check("load_state_early", {29'd0, state}, 32'd0);
    send_byte(8'h4F);
    check("load_k_valid", {31'd0, tx_valid}, 32'd1);
    check("load_k_data", {24'd0, tx_data}, 32'h4B);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("load_k_once", {31'd0, tx_valid}, 32'd0);
    check("load_state_wait", {29'd0, state}, 32'd1);
    check("load_mask", {27'd0, mask}, 32'd0);
  endtask

  task automatic do_guess(input vec_t v, input int id);
    int unsigned n = 0;
    rx_data  = v.rx;
    rx_ready = 1'b1;
    do begin
      @(negedge clk);
      rx_ready = 1'b0;
      rx_data  = 8'h00;
      n++;
    end while (!tx_valid && n < 40);
    check($sformatf("latency[%0d]", id), n, WL + 2);
    check($sformatf("tx_data[%0d]", id), {24'd0, tx_data}, {24'd0, v.tx});
    for (int unsigned k = 0; k < v.hold; k++) begin
      @(negedge clk);
      check($sformatf("hold_valid[%0d]", id), {31'd0, tx_valid}, 32'd1);
      check($sformatf("hold_data[%0d]", id), {24'd0, tx_data}, {24'd0, v.tx});
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check($sformatf("tx_drop[%0d]", id), {31'd0, tx_valid}, 32'd0);
    check($sformatf("mask[%0d]", id), {27'd0, mask}, {27'd0, v.mask});
    check($sformatf("mistakes[%0d]", id), {29'd0, mistakes}, {29'd0, v.mist});
    check($sformatf("game_over[%0d]", id), {31'd0, game_over}, {31'd0, v.go});
    check($sformatf("win[%0d]", id), {31'd0, win}, {31'd0, v.win});
    check($sformatf("state[%0d]", id), {29'd0, state}, v.go ? 32'd5 : 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, {29'd0, state}, 32'd0);
    check({tag, "_mask"}, {27'd0, mask}, 32'd0);
    check({tag, "_mistakes"}, {29'd0, mistakes}, 32'd0);
    check({tag, "_game_over"}, {31'd0, game_over}, 32'd0);
    check({tag, "_win"}, {31'd0, win}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n;

    vecs[0]  = '{8'h4C, 0,  8'h2B, 5'b01100, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{8'h4C, 0,  8'h3D, 5'b01100, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{8'h5A, 0,  8'h2D, 5'b01100, 3'd1, 1'b0, 1'b0};
    vecs[3]  = '{8'h51, 0,  8'h2D, 5'b01100, 3'd2, 1'b0, 1'b0};
    vecs[4]  = '{8'h58, 0,  8'h2D, 5'b01100, 3'd3, 1'b0, 1'b0};
    vecs[5]  = '{8'h56, 0,  8'h2D, 5'b01100, 3'd4, 1'b0, 1'b0};
    vecs[6]  = '{8'h4A, 0,  8'h2D, 5'b01100, 3'd5, 1'b0, 1'b0};
    vecs[7]  = '{8'h42, 0,  8'h4C, 5'b01100, 3'd6, 1'b1, 1'b0};
    vecs[8]  = '{8'h48, 0,  8'h2B, 5'b00001, 3'd0, 1'b0, 1'b0};
    vecs[9]  = '{8'h45, 0,  8'h2B, 5'b00011, 3'd0, 1'b0, 1'b0};
    vecs[10] = '{8'h4C, 0,  8'h2B, 5'b01111, 3'd0, 1'b0, 1'b0};
    vecs[11] = '{8'h4F, 10, 8'h57, 5'b11111, 3'd0, 1'b1, 1'b1};

    nRst     = 1'b0;
    rx_data  = 8'h00;
    rx_ready = 1'b0;
    tx_ready = 1'b0;
    #20;
    check_reset_outputs("por");
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);

    // Game 1: losing sequence.
    load_hello();
    for (int i = 0; i < 8; i++) do_guess(vecs[i], i);
    send_byte(8'h41);
    repeat (WL + 4) @(negedge clk);
    check("end_ignores_tx", {31'd0, tx_valid}, 32'd0);
    check("end_state", {29'd0, state}, 32'd5);
    check("end_mistakes_hold", {29'd0, mistakes}, 32'd6);
    send_byte(8'h21);
    check_reset_outputs("restart1");

    // Game 2: winning sequence, last response back-pressured.
    load_hello();
    for (int i = 8; i < 12; i++) do_guess(vecs[i], i);
    send_byte(8'h21);
    check_reset_outputs("restart2");

    // Overrun during CHECK, then Restart clears it.
    load_hello();
    rx_data  = 8'h41;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    check("ovr_in_check", {29'd0, state}, 32'd2);
    send_byte(8'h43);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    n = 0;
    while (!tx_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ovr_dropped_rsp", {24'd0, tx_data}, 32'h2D);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("ovr_mistakes", {29'd0, mistakes}, 32'd1);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);
    send_byte(8'h21);
    check_reset_outputs("ovr_restart");

    // Async reset mid-CHECK with overrun set.
    load_hello();
    rx_data  = 8'h45;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    send_byte(8'h43);
    check("rst_chk_ovr", {31'd0, overrun}, 32'd1);
    check("rst_chk_state", {29'd0, state}, 32'd2);
    #10 nRst = 1'b0;
    #1;
    check_reset_outputs("rst_check");
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);

    // Async reset while a response is pending.
    load_hello();
    rx_data  = 8'h48;
    rx_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rx_ready = 1'b0;
      n++;
    end while (!tx_valid && n < 40);
    check("rst_rep_valid", {31'd0, tx_valid}, 32'd1);
    check("rst_rep_mask", {27'd0, mask}, 32'd1);
    #10 nRst = 1'b0;
    #1;
    check_reset_outputs("rst_report");
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
